d_hazard_ctrl: RTL and testbench

D_HAZARD_CTRL -- requirements
Module: D_hazard_ctrl

---
 rtl/d_hazard_ctrl_pkg.sv | 11 +
 rtl/d_hazard_ctrl_md_timer.sv | 38 +++
 rtl/d_hazard_ctrl.sv | 57 +++++
 tb/tb_d_hazard_ctrl.sv | 133 +++++++++++++
 4 files changed

// File: rtl/d_hazard_ctrl_pkg.sv
// mips_pkg: opcode/funct constants and HI/LO timer state shared by the hazard unit
package mips_pkg;
  localparam logic [5:0] SPECIAL = 6'b000000;
  localparam logic [5:0] MFHI    = 6'b010000;
  localparam logic [5:0] MFLO    = 6'b010010;
  localparam logic [5:0] MULT    = 6'b011000;
  localparam logic [5:0] MULTU   = 6'b011001;
  localparam logic [5:0] DIV     = 6'b011010;
  localparam logic [5:0] DIVU    = 6'b011011;
  typedef enum logic {IDLE, BUSY} md_state_t;
endpackage

// File: rtl/d_hazard_ctrl_md_timer.sv
// D_md_timer: HI/LO busy timer; i_start/i_op (0 mult, 1 div) launch an op, o_busy high exactly LAT cycles
module D_md_timer
  import mips_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_op,
  output logic o_busy
);
  localparam int CW = $clog2(MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT);
  md_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE && i_start) begin
      state_nxt = BUSY;
      cnt_nxt   = i_op ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
    end else if (state == BUSY) begin
      state_nxt = (cnt == '0) ? IDLE : BUSY;
      cnt_nxt   = (cnt == '0) ? cnt : cnt - CW'(1);
    end
  end
  assign o_busy = (state == BUSY);
endmodule

// File: rtl/d_hazard_ctrl.sv
// d_hazard_ctrl: D-stage hazard unit; D/E/M register fields in, stall/flush/forward and HI/LO start/op/busy out
module d_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [4:0] i_rsD,
  input  logic [4:0] i_rtD,
  input  logic [5:0] i_opcodeD,
  input  logic [5:0] i_functD,
  input  logic       i_branchD,
  input  logic       i_branch_takenD,
  input  logic [4:0] i_writeregE,
  input  logic [4:0] i_writeregM,
  input  logic       i_regwriteE,
  input  logic       i_regwriteM,
  input  logic       i_memtoregE,
  input  logic       i_memtoregM,
  output logic       o_stallF,
  output logic       o_stallD,
  output logic       o_flushD,
  output logic       o_flushE,
  output logic       o_fwdAD,
  output logic       o_fwdBD,
  output logic       o_md_start,
  output logic       o_md_op,
  output logic       o_md_busy
);
  logic hit_e, hit_m, lwstall, brstall, mdstall, stall, md_instr, mf_instr;
  // $0 never hazards, so a zero destination never matches
  assign hit_e    = (i_writeregE != '0) && (i_writeregE == i_rsD || i_writeregE == i_rtD);
  assign hit_m    = (i_writeregM != '0) && (i_writeregM == i_rsD || i_writeregM == i_rtD);
  assign md_instr = (i_opcodeD == SPECIAL) && (i_functD inside {MULT, MULTU, DIV, DIVU});
  assign mf_instr = (i_opcodeD == SPECIAL) && (i_functD inside {MFHI, MFLO});
  assign lwstall  = i_memtoregE && i_regwriteE && hit_e;
  assign brstall  = i_branchD && ((i_regwriteE && hit_e) || (i_memtoregM && hit_m));
  assign mdstall  = o_md_busy && (md_instr || mf_instr);
  assign stall    = lwstall || brstall || mdstall;
  assign o_stallF = stall;
  assign o_stallD = stall;
  assign o_flushE = stall;
  assign o_flushD = i_branch_takenD && !stall;
  assign o_fwdAD  = (i_rsD != '0) && (i_rsD == i_writeregM) && i_regwriteM;
  assign o_fwdBD  = (i_rtD != '0) && (i_rtD == i_writeregM) && i_regwriteM;
  assign o_md_start = md_instr && !stall && !i_rst;
  assign o_md_op    = i_functD inside {DIV, DIVU};
  D_md_timer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(o_md_start),
    .i_op   (o_md_op),
    .o_busy (o_md_busy)
  );
endmodule

// File: tb/tb_d_hazard_ctrl.sv
// tb_d_hazard_ctrl: directed stimulus with a cycle-timestamp reference model and hand-computed literal checks
module tb_d_hazard_ctrl;
  localparam int ML = 4;
  localparam int DL = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rs = '0, rt = '0, we = '0, wm = '0;
  logic [5:0] opc = '0, fn = '0;
  logic br = 1'b0, tk = 1'b0, rwe = 1'b0, rwm = 1'b0, mte = 1'b0, mtm = 1'b0;
  logic stf, std, fld, fle, fa, fb, st, op, bz;
  int n_vec = 0, n_err = 0, cyc = 0, busy_end = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  d_hazard_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .i_clk(clk), .i_rst(rst), .i_rsD(rs), .i_rtD(rt), .i_opcodeD(opc), .i_functD(fn),
    .i_branchD(br), .i_branch_takenD(tk), .i_writeregE(we), .i_writeregM(wm),
    .i_regwriteE(rwe), .i_regwriteM(rwm), .i_memtoregE(mte), .i_memtoregM(mtm),
    .o_stallF(stf), .o_stallD(std), .o_flushD(fld), .o_flushE(fle), .o_fwdAD(fa),
    .o_fwdBD(fb), .o_md_start(st), .o_md_op(op), .o_md_busy(bz)
  );

  function automatic bit hz(logic [4:0] s, logic [4:0] d);
    return s != 5'd0 && s == d;
  endfunction
  function automatic bit m_md();
    return opc == 6'd0 && fn >= 6'd24 && fn <= 6'd27;
  endfunction
  function automatic bit m_div();
    return m_md() && fn >= 6'd26;
  endfunction
  function automatic bit m_stall();
    bit busy, lw, brs, mds;
    busy = cyc < busy_end;
    lw   = mte && rwe && (hz(rs, we) || hz(rt, we));
    brs  = br && ((rwe && (hz(rs, we) || hz(rt, we))) || (mtm && (hz(rs, wm) || hz(rt, wm))));
    mds  = busy && (m_md() || (opc == 6'd0 && (fn == 6'd16 || fn == 6'd18)));
    return lw || brs || mds;
  endfunction
  function automatic bit m_start();
    return m_md() && !m_stall() && !rst;
  endfunction

  task automatic chk(string name, logic [8:0] act, logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic settle();
    bit s;
    @(negedge clk);
    if (armed) begin
      s = m_stall();
      chk("model", {stf, std, fld, fle, fa, fb, st, st & op, bz},
          {s, s, tk && !s, s, hz(rs, wm) && rwm, hz(rt, wm) && rwm,
           m_start(), m_start() && m_div(), 1'(cyc < busy_end)});
    end
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) begin
      busy_end = cyc + 1;
      armed = 1'b1;
    end else if (m_start()) busy_end = cyc + 1 + (m_div() ? DL : ML);
    cyc++;
    #1;
  endtask

  task automatic clear();
    rs = '0; rt = '0; we = '0; wm = '0; opc = '0; fn = '0;
    br = 0; tk = 0; rwe = 0; rwm = 0; mte = 0; mtm = 0;
  endtask

  initial begin
    settle(); adv(); settle(); adv();
    rst = 1'b0;
    settle(); chk("reset_outs", {stf, std, fld, fle, fa, fb, st, op, bz}, 9'd0); adv();
    mte = 1; rwe = 1; we = 5'd8; rs = 5'd8;
    settle(); chk("lw_stall", {6'd0, stf, std, fle}, 9'b111); adv();
    we = 5'd0;
    settle(); chk("lw_r0", {6'd0, stf, std, fle}, 9'b000); adv();
    clear();
    br = 1; tk = 1; rs = 5'd9; rwe = 1; we = 5'd9;
    settle(); chk("br_stall", {7'd0, std, fld}, 9'b10); adv();
    rwe = 0; we = 0; wm = 5'd9; rwm = 1; mtm = 0;
    settle(); chk("br_fwd", {6'd0, std, fa, fld}, 9'b011); adv();
    clear();
    br = 1; rt = 5'd7; wm = 5'd7; mtm = 1;
    settle(); chk("br_load_m", {8'd0, std}, 9'b1); adv();
    clear();
    rt = 5'd12; wm = 5'd12; rwm = 1;
    settle(); chk("fwd_b", {7'd0, fa, fb}, 9'b01); adv();
    rt = 5'd0; wm = 5'd0;
    settle(); chk("fwd_r0", {7'd0, fa, fb}, 9'b00); adv();
    clear();
    fn = 6'b011000;
    settle(); chk("mult_start", {7'd0, st, op}, 9'b10); adv();
    fn = 6'b010010;
    for (int i = 0; i < ML; i++) begin
      settle(); chk("mflo_stall", {7'd0, bz, std}, 9'b11); adv();
    end
    settle(); chk("mflo_go", {7'd0, bz, std}, 9'b00); adv();
    fn = 6'b011010;
    settle(); chk("div1_start", {7'd0, st, op}, 9'b11); adv();
    for (int i = 0; i < DL; i++) begin
      settle(); chk("div2_wait", {6'd0, bz, std, st}, 9'b110); adv();
    end
    settle(); chk("div2_start", {5'd0, bz, std, st, op}, 9'b0011); adv();
    fn = 6'b010000;
    for (int i = 0; i < 9; i++) begin
      settle(); chk("mfhi_wait", {7'd0, bz, std}, 9'b11); adv();
    end
    rst = 1'b1;
    settle(); chk("rst_cycle", {7'd0, bz, st}, 9'b10); adv();
    rst = 1'b0;
    settle(); chk("after_rst", {7'd0, bz, std}, 9'b00); adv();
    clear();
    fn = 6'b011000; mte = 1; rwe = 1; we = 5'd5; rs = 5'd5;
    settle(); chk("coll_block", {7'd0, std, st}, 9'b10); adv();
    mte = 0; rwe = 0; we = 0;
    settle(); chk("coll_issue", {7'd0, bz, st}, 9'b01); adv();
    clear();
    settle(); chk("coll_busy", {8'd0, bz}, 9'b1); adv();
    repeat (ML + 1) begin settle(); adv(); end
    settle(); chk("final_idle", {8'd0, bz}, 9'b0); adv();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
